// File: rtl/cs161_multicycle_control.sv
// Moore-FSM multi-cycle control unit for the cs161 MIPS core, with memory timeout and retire counter.
// Define CS161_BNE_EN to add BNE (opcode 0x05) via the BRANCH state with branch_ne.
module cs161_multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instr_op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_dbg,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef CS161_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_ERROR    = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_err;
  logic [1:0]       w_err_set;
  logic [TW-1:0]    r_tcnt;
  logic [CNT_W-1:0] r_retired;
  logic             w_wait;
  logic             w_tmo;
  logic             w_retire;
`ifdef CS161_BNE_EN
  logic [5:0]       r_op;
`endif

  // A wait cycle is a memory-facing state with no completion; the Nth one times out.
  assign w_wait   = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                    && !mem_ready;
  assign w_tmo    = w_wait && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  // Only completion states ever transition into FETCH, so any such entry retires.
  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

  always_comb begin
    w_next    = r_state;
    w_err_set = ERR_NONE;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_tmo) begin
          w_next    = S_ERROR;
          w_err_set = ERR_TMO;
        end
      end
      S_DECODE: begin
        case (instr_op)
          OP_RTYPE:      w_next = S_R_EX;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ:        w_next = S_BRANCH;
`ifdef CS161_BNE_EN
          OP_BNE:        w_next = S_BRANCH;
`endif
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = S_ADDI_EX;
          default: begin
            w_next    = S_ERROR;
            w_err_set = ERR_ILL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (instr_op == OP_LW) begin
          w_next = S_MEM_RD;
        end else if (instr_op == OP_SW) begin
          w_next = S_MEM_WR;
        end else begin
          w_next    = S_ERROR;
          w_err_set = ERR_ILL;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_tmo) begin
          w_next    = S_ERROR;
          w_err_set = ERR_TMO;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_tmo) begin
          w_next    = S_ERROR;
          w_err_set = ERR_TMO;
        end
      end
      S_MEM_WB:  w_next = S_FETCH;
      S_R_EX:    w_next = S_R_WB;
      S_R_WB:    w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_ADDI_WB: w_next = S_FETCH;
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_err     <= ERR_NONE;
      r_tcnt    <= '0;
      r_retired <= '0;
`ifdef CS161_BNE_EN
      r_op      <= '0;
`endif
    end else begin
      r_state <= w_next;
      if ((r_err == ERR_NONE) && (w_err_set != ERR_NONE)) begin
        r_err <= w_err_set;
      end
      if (mem_ready || (w_next != r_state)) begin
        r_tcnt <= '0;
      end else if (w_wait) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
`ifdef CS161_BNE_EN
      if (r_state == S_DECODE) begin
        r_op <= instr_op;
      end
`endif
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEM_ADDR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
`ifdef CS161_BNE_EN
          branch_ne     = (r_op == OP_BNE);
`endif
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = rst ? 4'd0 : r_state;
  assign err       = r_err;
  assign retired   = r_retired;

endmodule

// File: doc/cs161_multicycle_control.md
Name: cs161_multicycle_control

Overview:
- Moore-FSM control unit for the multi-cycle generation of the cs161 MIPS processor.
- Replaces the combinational single-cycle control decode.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and stalls on a mem_ready handshake.
- Flags illegal opcodes and memory timeouts, and counts retired instructions for debug.

Parameters:
- TIMEOUT_CYCLES, 16: max consecutive cycles a memory state waits for mem_ready before error. Minimum 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_op  in  6  opcode from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the branch condition holds.
- branch_ne  out  1  branch condition inverted (BNE).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback source: 1 = MDR.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = shifted imm.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = unused.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state_dbg  out  4  current state encoding.
- err  out  2  sticky error code: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- One clock, clk. rst is synchronous, active-high.
- On a clk edge with rst high:
  - state goes to FETCH(0); err = 00; retired = 0; timeout counter = 0.
  - All control outputs are forced 0 while rst is high; state_dbg = 0.
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5.
  - R_EX = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11, ERROR = 15.
- Outputs are a pure decode of the state register (Moore); no opcode-to-output combinational path.
- FETCH:
  - Asserts mem_read, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write are asserted only while mem_ready = 1.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Asserts alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by instr_op:
    - 0x00 → R_EX
    - 0x23 or 0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x08 → ADDI_EX
    - anything else → ERROR with err = 01.
- MEM_ADDR:
  - Asserts alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - 0x23 → MEM_RD; 0x2B → MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; then FETCH (retire).
- MEM_WR: mem_write = 1, i_or_d = 1; holds until mem_ready, then FETCH (retire).
- R_EX: alu_src_a = 1, alu_src_b = 00, alu_op = 10; then R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; then FETCH (retire).
- BRANCH:
  - Asserts alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - Then FETCH (retire).
- JUMP: pc_write = 1, pc_source = 10; then FETCH (retire).
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00; then ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0; then FETCH (retire).
- Latency in cycles with zero wait states:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each memory wait cycle adds 1.
- Timeout:
  - The counter increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready = 0.
  - It clears on mem_ready or on any state change.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0: go to ERROR, err = 10.
  - If mem_ready rises on that same cycle, it wins and there is no error.
- ERROR:
  - All control outputs 0; remains there until rst.
  - err holds the first error that occurred.
- retired:
  - Increments by 1 on every transition into FETCH from a completion state.
  - Wraps modulo 2^CNT_W.
  - Never increments on the reset-to-FETCH entry.
- Reset mid-instruction: abandons the instruction and does not retire it; in-flight mem_read/mem_write drop in the reset cycle.

Optional Feature:
- Macro: CS161_BNE_EN.
- Defined:
  - Opcode 0x05 in DECODE → BRANCH.
  - BRANCH drives the same outputs as for BEQ, plus branch_ne = 1 when the latched op is 0x05.
  - The opcode is latched in DECODE.
- Undefined:
  - 0x05 is illegal (ERROR, err = 01).
  - branch_ne is tied to 0.

Test Plan:
- Reset then R-type, mem_ready = 1 constantly → state_dbg sequence 0,1,6,7,0; reg_write = 1 and reg_dst = 1 in state 7 only; retired = 1.
- lw (0x23) with mem_ready held low 3 cycles in MEM_RD → states 0,1,2,3,3,3,3,4,0; reg_write with mem_to_reg = 1 in state 4; retired increments once.
- beq (0x04) then j (0x02) → BRANCH asserts pc_write_cond = 1, alu_op = 01; JUMP asserts pc_write = 1, pc_source = 10; retired = 2.
- Opcode 0x3F in DECODE → state 15, err = 01, all controls 0 until rst; rst clears err and returns state_dbg = 0.
- TIMEOUT_CYCLES = 4, FETCH with mem_ready = 0 for 4 cycles → ERROR, err = 10. Repeat with mem_ready rising on the 4th cycle → DECODE, err = 00.
- Opcode 0x05: with CS161_BNE_EN → BRANCH with branch_ne = 1; without → err = 01. Separately, CNT_W = 4 with 17 sw instructions → retired = 1.
